// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit holding HI/LO for the 5-stage MIPS pipeline.
// MULT/MULTU/DIV/DIVU run for a fixed latency; MTHI/MTLO write in one cycle.
// Define MD_MADD_EN to add MADD (md_op 6) and MSUB (md_op 7) accumulate ops.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned LAT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(LAT_MAX + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    r_state;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_op;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic [0:0]    w_state_nxt;
  logic          w_busy_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_load;
  logic [31:0]   w_hi_nxt;
  logic [31:0]   w_lo_nxt;
  logic          w_multi_op;
  logic          w_mul_class;
  logic [CW-1:0] w_lat;
  logic [63:0]   w_res;
  logic [63:0]   w_prod_s;
  logic [63:0]   w_prod_u;
  logic          w_sdiv;
  logic [31:0]   w_dvd;
  logic [31:0]   w_dvs;
  logic [31:0]   w_uq;
  logic [31:0]   w_ur;
  logic [31:0]   w_q;
  logic [31:0]   w_r;

  assign busy     = r_busy;
  assign md_stall = start | r_busy;
  assign HI       = r_hi;
  assign LO       = r_lo;

  // Decode which incoming ops launch a multi-cycle run.
  always_comb begin
    w_multi_op = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                 (md_op == OP_DIV)  || (md_op == OP_DIVU);
`ifdef MD_MADD_EN
    if ((md_op == OP_MADD) || (md_op == OP_MSUB)) w_multi_op = 1'b1;
`endif
  end

  // Latency of the latched op: everything except DIV/DIVU uses the multiply latency.
  always_comb begin
    w_mul_class = (r_op != OP_DIV) && (r_op != OP_DIVU);
    w_lat       = w_mul_class ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
  end

  // Result datapath from latched operands; signed divide via magnitudes plus sign fix-up.
  always_comb begin
    w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    w_sdiv   = (r_op == OP_DIV);
    w_dvd    = (w_sdiv && r_a[31]) ? -r_a : r_a;
    w_dvs    = (w_sdiv && r_b[31]) ? -r_b : r_b;
    w_uq     = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
    w_ur     = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
    w_q      = (w_sdiv && (r_a[31] ^ r_b[31])) ? -w_uq : w_uq;
    w_r      = (w_sdiv && r_a[31]) ? -w_ur : w_ur;
    case (r_op)
      OP_MULT:          w_res = w_prod_s;
      OP_MULTU:         w_res = w_prod_u;
      OP_DIV, OP_DIVU:  w_res = (r_b == 32'd0) ? {r_a, 32'hFFFF_FFFF} : {w_r, w_q};
`ifdef MD_MADD_EN
      OP_MADD:          w_res = {r_hi, r_lo} + w_prod_s;
      OP_MSUB:          w_res = {r_hi, r_lo} - w_prod_s;
`endif
      default:          w_res = {r_hi, r_lo};
    endcase
  end

  // Next-state, counter and HI/LO update; starts during RUN are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_multi_op) begin
            w_load      = 1'b1;
            w_state_nxt = S_RUN;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = CW'(1);
          end else if (md_op == OP_MTHI) begin
            w_hi_nxt = A;
          end else if (md_op == OP_MTLO) begin
            w_lo_nxt = A;
          end
        end
      end
      S_RUN: begin
        if (r_cnt == w_lat) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_hi_nxt    = w_res[63:32];
          w_lo_nxt    = w_res[31:0];
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, operand latch and HI/LO registers; reset aborts any run without a write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_op    <= 3'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      if (w_load) begin
        r_op <= md_op;
        r_a  <= A;
        r_b  <= B;
      end
    end
  end

  // A start arriving while busy must never reload the operand latch.
  a_no_load_when_busy: assert property (@(posedge clk) disable iff (!reset) r_busy |-> !w_load);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed bench for md_unit with an arithmetic reference model and per-cycle compare.
module tb_md_unit;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] A     = 32'd0;
  logic [31:0] B     = 32'd0;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int total  = 0;
  int bad    = 0;
  bit chk_en = 1'b0;

`ifdef MD_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op), .A(A), .B(B),
    .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on 64-bit integers.
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] acc);
    longint sa;
    longint sb;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd6: return acc + 64'(sa * sb);
      3'd7: return acc - 64'(sa * sb);
      default: return acc;
    endcase
  endfunction

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_rem = 0;
  logic [2:0]  m_op = 3'd0;
  logic [31:0] m_a = 32'd0;
  logic [31:0] m_b = 32'd0;

  // Model: countdown of remaining busy cycles, result computed at the commit edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) {m_hi, m_lo} = md_ref(m_op, m_a, m_b, {m_hi, m_lo});
    end else if (start) begin
      if (md_op <= 3'd3 || (MADD_EN && md_op >= 3'd6)) begin
        m_op = md_op; m_a = A; m_b = B;
        m_rem = (md_op == 3'd2 || md_op == 3'd3) ? 10 : 5;
      end else if (md_op == 3'd4) begin
        m_hi = A;
      end else if (md_op == 3'd5) begin
        m_lo = A;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(m_rem != 0));
      check("cyc_stall", 32'(md_stall), 32'(start | (m_rem != 0)));
      check("cyc_hi", HI, m_hi);
      check("cyc_lo", LO, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    start = 1'b1; md_op = op; A = a; B = b;
    @(posedge clk); #2;
    start = 1'b0; md_op = 3'd0; A = $urandom; B = $urandom;
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    @(posedge clk); #2;
    start = 1'b1; md_op = op; A = a;
    @(posedge clk); #2;
    start = 1'b0; md_op = 3'd0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (busy) check("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    #1 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_stall", 32'(md_stall), 32'd0);

    // MTHI then MTLO back to back
    @(posedge clk); #2;
    start = 1'b1; md_op = 3'd4; A = 32'h1234_5678;
    @(negedge clk);
    check("mthi_stall", 32'(md_stall), 32'd1);
    @(posedge clk); #2;
    md_op = 3'd5; A = 32'h9ABC_DEF0;
    @(negedge clk);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mtlo_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    start = 1'b0; md_op = 3'd0;
    @(negedge clk);
    check("mtlo_lo", LO, 32'h9ABC_DEF0);
    check("mt_stall_off", 32'(md_stall), 32'd0);

    // Reset in the third busy cycle of DIV 100/7
    issue(3'd2, 32'd100, 32'd7);
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("midrst_hi", HI, 32'd0);
    check("midrst_lo", LO, 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (14) @(negedge clk);
    check("midrst_nowr_hi", HI, 32'd0);
    check("midrst_nowr_lo", LO, 32'd0);

    // MULT / MULTU -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    check("mult_lat", 32'(n), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    // DIV -7/2, DIVU 7/0, DIV overflow
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(n);
    check("div_lat", 32'(n), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    issue(3'd3, 32'd7, 32'd0);
    wait_done(n);
    check("divz_lat", 32'(n), 32'd10);
    check("divz_lo", LO, 32'hFFFF_FFFF);
    check("divz_hi", HI, 32'd7);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    check("divov_lo", LO, 32'h8000_0000);
    check("divov_hi", HI, 32'd0);

    // Operand latch and start ignored while busy
    issue(3'd0, 32'd3, 32'd4);
    @(posedge clk); #2;
    start = 1'b1; md_op = 3'd1; A = 32'd5; B = 32'd6;
    @(posedge clk); #2;
    start = 1'b0; md_op = 3'd0;
    wait_done(n);
    check("ign_rest_lat", 32'(n), 32'd3);
    check("ign_lo", LO, 32'd12);
    check("ign_hi", HI, 32'd0);
    repeat (3) @(negedge clk);
    check("ign_idle", 32'(busy), 32'd0);

`ifdef MD_MADD_EN
    mt(3'd4, 32'd0);
    mt(3'd5, 32'd10);
    issue(3'd6, 32'd2, 32'd3);
    wait_done(n);
    check("madd_lat", 32'(n), 32'd5);
    check("madd_lo", LO, 32'd16);
    check("madd_hi", HI, 32'd0);
    issue(3'd7, 32'hFFFF_FFFF, 32'd20);
    wait_done(n);
    check("msub_lo", LO, 32'd36);
    check("msub_hi", HI, 32'd0);
`else
    mt(3'd5, 32'd10);
    issue(3'd6, 32'd2, 32'd3);
    repeat (6) @(negedge clk);
    check("op6_busy", 32'(busy), 32'd0);
    check("op6_lo", LO, 32'd10);
    check("op6_hi", HI, 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
